// File: rtl/proc_gen.sv
// proc_gen: parametrised multicycle processor (IDLE/T1/T2/T3/MEM FSM) with a MemReady-handshaked memory port.
// Optional build macro PROC_GEN_MULT_EN turns opcode 11 into an unsigned multiply.
module proc_gen #(
    parameter int N       = 16,
    parameter int TIMEOUT = 0
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    input  logic         MemReady,
    output logic         Done,
    output logic         Err,
    output logic [N-1:0] BusWires,
    output logic [N-1:0] ADDR,
    output logic [N-1:0] DOUT,
    output logic         W
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_MEM} state_t;

    localparam logic [3:0] OP_LD   = 4'd0;
    localparam logic [3:0] OP_ST   = 4'd1;
    localparam logic [3:0] OP_MVNZ = 4'd2;
    localparam logic [3:0] OP_MV   = 4'd3;
    localparam logic [3:0] OP_MVI  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
`ifdef PROC_GEN_MULT_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
`endif
    localparam logic [N-1:0] N_VAL = N'(N);

    state_t       state_q;
    logic [9:0]   ir_q;
    logic [N-1:0] regs_q [8];
    logic [N-1:0] a_q;
    logic [N-1:0] g_q;
    logic [N-1:0] addr_q;
    logic [N-1:0] dout_q;
    logic [31:0]  cnt_q;

    logic [3:0]   op;
    logic [2:0]   rx;
    logic [2:0]   ry;
    logic [N-1:0] rxVal;
    logic [N-1:0] ryVal;
    logic [N-1:0] g_d;
    logic [N-1:0] busWires;
    logic         isAlu;
    logic         timeoutHit;

    assign op    = ir_q[9:6];
    assign rx    = ir_q[5:3];
    assign ry    = ir_q[2:0];
    assign rxVal = regs_q[rx];
    assign ryVal = regs_q[ry];

    // The wait that would bring the count up to TIMEOUT ends the access instead.
    assign timeoutHit = (TIMEOUT != 0) && !MemReady && (cnt_q == 32'(TIMEOUT - 1));

`ifdef PROC_GEN_MULT_EN
    assign isAlu = (op >= OP_ADD) && (op <= OP_MUL);
`else
    assign isAlu = (op >= OP_ADD) && (op <= OP_SRL);
`endif

    always_comb begin
        g_d = g_q;
        case (op)
            OP_ADD: g_d = a_q + ryVal;
            OP_SUB: g_d = a_q - ryVal;
            OP_OR:  g_d = a_q | ryVal;
            OP_SLT: begin
                g_d    = '0;
                g_d[0] = $signed(a_q) < $signed(ryVal);
            end
            OP_SLL: g_d = (ryVal >= N_VAL) ? '0 : (a_q << ryVal);
            OP_SRL: g_d = (ryVal >= N_VAL) ? '0 : (a_q >> ryVal);
`ifdef PROC_GEN_MULT_EN
            OP_MUL: g_d = a_q * ryVal;
`endif
            default: g_d = g_q;
        endcase
    end

    always_comb begin
        busWires = '0;
        Done     = 1'b0;
        Err      = 1'b0;
        W        = 1'b0;
        case (state_q)
            S_T1: begin
                if (op == OP_LD || op == OP_ST) begin
                    busWires = ryVal;
                end else if (op == OP_MVNZ) begin
                    if (g_q != '0) busWires = ryVal;
                    Done = 1'b1;
                end else if (op == OP_MV) begin
                    busWires = ryVal;
                    Done     = 1'b1;
                end else if (op == OP_MVI) begin
                    busWires = DIN;
                    Done     = 1'b1;
                end else if (isAlu) begin
                    busWires = rxVal;
                end else begin
                    Done = 1'b1;
                end
            end
            S_T2: busWires = (op == OP_ST) ? rxVal : ryVal;
            S_T3: begin
                busWires = g_q;
                Done     = 1'b1;
            end
            S_MEM: begin
                W = (op == OP_ST);
                if (MemReady) begin
                    Done = 1'b1;
                    if (op == OP_LD) busWires = DIN;
                end else if (timeoutHit) begin
                    Done = 1'b1;
                    Err  = 1'b1;
                end
            end
            default: busWires = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Run) begin
                        ir_q    <= DIN[9:0];
                        state_q <= S_T1;
                    end
                end
                S_T1: begin
                    if (op == OP_LD) begin
                        addr_q  <= busWires;
                        cnt_q   <= '0;
                        state_q <= S_MEM;
                    end else if (op == OP_ST) begin
                        addr_q  <= busWires;
                        state_q <= S_T2;
                    end else if (isAlu) begin
                        a_q     <= busWires;
                        state_q <= S_T2;
                    end else begin
                        if (op == OP_MV || op == OP_MVI || (op == OP_MVNZ && g_q != '0))
                            regs_q[rx] <= busWires;
                        state_q <= S_IDLE;
                    end
                end
                S_T2: begin
                    if (op == OP_ST) begin
                        dout_q  <= busWires;
                        cnt_q   <= '0;
                        state_q <= S_MEM;
                    end else begin
                        g_q     <= g_d;
                        state_q <= S_T3;
                    end
                end
                S_T3: begin
                    regs_q[rx] <= g_q;
                    state_q    <= S_IDLE;
                end
                S_MEM: begin
                    if (MemReady) begin
                        if (op == OP_LD) regs_q[rx] <= DIN;
                        state_q <= S_IDLE;
                    end else if (timeoutHit) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BusWires = busWires;
    assign ADDR     = addr_q;
    assign DOUT     = dout_q;
endmodule

// File: tb/tb_proc_gen.sv
// Directed self-checking bench for proc_gen (N=16, TIMEOUT=5).
// Expected values are hand-computed; outputs are sampled 1 time unit after the falling edge.
module tb_proc_gen;
    localparam int N       = 16;
    localparam int TIMEOUT = 5;

    logic         Clock;
    logic         Reset;
    logic         Run;
    logic [N-1:0] DIN;
    logic         MemReady;
    logic         Done;
    logic         Err;
    logic [N-1:0] BusWires;
    logic [N-1:0] ADDR;
    logic [N-1:0] DOUT;
    logic         W;

    int checks   = 0;
    int failures = 0;

    proc_gen #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Run      (Run),
        .DIN      (DIN),
        .MemReady (MemReady),
        .Done     (Done),
        .Err      (Err),
        .BusWires (BusWires),
        .ADDR     (ADDR),
        .DOUT     (DOUT),
        .W        (W)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Guards against a hung handshake.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N-1:0] enc(input int op, input int x, input int y);
        return N'((op << 6) | (x << 3) | y);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReg(input int idx, input logic [N-1:0] exp);
        checkOutput($sformatf("R%0d", idx), 32'(dut.regs_q[idx]), 32'(exp));
    endtask

    // Presents an instruction in IDLE and returns at the falling edge inside T1.
    task automatic applyStimulus(input logic [N-1:0] instr);
        Run = 1'b1;
        DIN = instr;
        #1 checkOutput("idle_done", Done, 0);
        @(negedge Clock);
        Run = 1'b0;
        DIN = '0;
    endtask

    task automatic runMvi(input int x, input logic [N-1:0] imm);
        applyStimulus(enc(4, x, 0));
        DIN = imm;
        #1 checkOutput("mvi_done", Done, 1);
        checkOutput("mvi_bus", BusWires, imm);
        @(negedge Clock);
        DIN = '0;
        checkReg(x, imm);
    endtask

    task automatic runOneCycle(input string tag, input int op, input int x, input int y,
                               input logic [N-1:0] expBus);
        applyStimulus(enc(op, x, y));
        #1 checkOutput({tag, "_done"}, Done, 1);
        checkOutput({tag, "_bus"}, BusWires, expBus);
        @(negedge Clock);
    endtask

    task automatic runAlu(input string tag, input int op, input int x, input int y,
                          input logic [N-1:0] expRx, input logic [N-1:0] expRy,
                          input logic [N-1:0] expRes);
        applyStimulus(enc(op, x, y));
        #1 checkOutput({tag, "_t1_bus"}, BusWires, expRx);
        checkOutput({tag, "_t1_done"}, Done, 0);
        @(negedge Clock);
        #1 checkOutput({tag, "_t2_bus"}, BusWires, expRy);
        checkOutput({tag, "_t2_done"}, Done, 0);
        @(negedge Clock);
        #1 checkOutput({tag, "_t3_bus"}, BusWires, expRes);
        checkOutput({tag, "_t3_done"}, Done, 1);
        @(negedge Clock);
        checkReg(x, expRes);
    endtask

    initial begin
        Reset    = 1'b1;
        Run      = 1'b0;
        DIN      = '0;
        MemReady = 1'b0;
        repeat (2) @(negedge Clock);
        checkOutput("rst_done", Done, 0);
        checkOutput("rst_err", Err, 0);
        checkOutput("rst_w", W, 0);
        checkOutput("rst_bus", BusWires, 0);
        checkOutput("rst_addr", ADDR, 0);
        checkOutput("rst_dout", DOUT, 0);
        checkOutput("rst_state", 32'(dut.state_q), 0);
        Reset = 1'b0;

        // mvi R0 with the opcode word 0x100, immediate 0x1234 in T1
        runMvi(0, 16'h1234);
        checkOutput("idle_after_mvi", Done, 0);

        // add wraps, then mvnz sees G=0
        runMvi(1, 16'hFFFF);
        runMvi(2, 16'h0001);
        runMvi(3, 16'h5555);
        runAlu("add", 5, 1, 2, 16'hFFFF, 16'h0001, 16'h0000);
        runOneCycle("mvnz_g0", 2, 3, 2, 16'h0000);
        checkReg(3, 16'h5555);

        // signed slt, then mvnz with G!=0
        runMvi(1, 16'h8000);
        runAlu("slt", 8, 1, 2, 16'h8000, 16'h0001, 16'h0001);
        runOneCycle("mvnz_g1", 2, 3, 2, 16'h0001);
        checkReg(3, 16'h0001);

        // shift amount equal to N clears the result
        runMvi(1, 16'h0003);
        runMvi(2, 16'h0010);
        runAlu("sll", 9, 1, 2, 16'h0003, 16'h0010, 16'h0000);
        runMvi(1, 16'h00F0);
        runMvi(2, 16'h0004);
        runAlu("srl", 10, 1, 2, 16'h00F0, 16'h0004, 16'h000F);
        runAlu("sub", 6, 1, 2, 16'h000F, 16'h0004, 16'h000B);
        runOneCycle("mv", 3, 6, 1, 16'h000B);
        checkReg(6, 16'h000B);
`ifdef PROC_GEN_MULT_EN
        runAlu("mul", 11, 1, 2, 16'h000B, 16'h0004, 16'h002C);
`else
        runOneCycle("op11", 11, 1, 2, 16'h0000);
        checkReg(1, 16'h000B);
        checkOutput("op11_g", 32'(dut.g_q), 32'h000B);
`endif
        runAlu("or", 7, 6, 2, 16'h000B, 16'h0004, 16'h000F);

        // st R4 -> [R5], MemReady after 3 wait cycles
        runMvi(5, 16'h0040);
        runMvi(4, 16'hBEEF);
        applyStimulus(enc(1, 4, 5));
        #1 checkOutput("st_t1_bus", BusWires, 16'h0040);
        @(negedge Clock);
        #1 checkOutput("st_addr", ADDR, 16'h0040);
        checkOutput("st_t2_bus", BusWires, 16'hBEEF);
        checkOutput("st_t2_w", W, 0);
        @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("st_wait_w", W, 1);
            checkOutput("st_wait_done", Done, 0);
            checkOutput("st_dout", DOUT, 16'hBEEF);
            @(negedge Clock);
        end
        MemReady = 1'b1;
        #1 checkOutput("st_ready_w", W, 1);
        checkOutput("st_ready_done", Done, 1);
        checkOutput("st_ready_err", Err, 0);
        @(negedge Clock);
        MemReady = 1'b0;
        #1 checkOutput("st_idle_w", W, 0);
        checkOutput("st_idle_done", Done, 0);

        // ld that times out in the 5th MEM cycle
        runMvi(7, 16'h7777);
        applyStimulus(enc(0, 7, 5));
        #1 checkOutput("ldto_t1_bus", BusWires, 16'h0040);
        @(negedge Clock);
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput("ldto_wait_done", Done, 0);
            checkOutput("ldto_wait_err", Err, 0);
            @(negedge Clock);
        end
        #1 checkOutput("ldto_done", Done, 1);
        checkOutput("ldto_err", Err, 1);
        @(negedge Clock);
        #1 checkReg(7, 16'h7777);
        checkOutput("ldto_idle_err", Err, 0);

        // ld with MemReady arriving exactly on the limit cycle
        applyStimulus(enc(0, 7, 5));
        @(negedge Clock);
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput("ld5_wait_done", Done, 0);
            @(negedge Clock);
        end
        MemReady = 1'b1;
        DIN      = 16'hCAFE;
        #1 checkOutput("ld5_done", Done, 1);
        checkOutput("ld5_err", Err, 0);
        checkOutput("ld5_bus", BusWires, 16'hCAFE);
        @(negedge Clock);
        MemReady = 1'b0;
        DIN      = '0;
        checkReg(7, 16'hCAFE);
        checkOutput("ld5_addr", ADDR, 16'h0040);

        // reset asserted during T2 of an add
        runMvi(1, 16'h0005);
        applyStimulus(enc(5, 1, 2));
        @(negedge Clock);
        Reset = 1'b1;
        #1 checkOutput("midrst_done", Done, 0);
        checkOutput("midrst_state", 32'(dut.state_q), 0);
        checkOutput("midrst_bus", BusWires, 0);
        checkOutput("midrst_addr", ADDR, 0);
        checkOutput("midrst_dout", DOUT, 0);
        for (int i = 0; i < 8; i++) checkReg(i, 16'h0000);
        @(negedge Clock);
        checkOutput("midrst_hold_done", Done, 0);
        Reset = 1'b0;
        runMvi(0, 16'h00AA);
        checkReg(1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/proc_gen.md
Name: proc_gen

Overview:
Parametrised successor to the team's 16-bit multicycle processor. The data width is generic and the control sequencing is an explicit FSM with a Run/Done handshake. Adds a memory port with a MemReady wait handshake for ld/st, plus a bounded memory-wait timeout with an error flag. The block sits between the instruction/data source on DIN and external memory; all datapath traffic goes over BusWires.

Parameters:
N, 16, datapath width (>= 10); R0..R7, A, G, ADDR, DOUT are all N bits
TIMEOUT, 0, max cycles spent in MEM waiting for MemReady; 0 = wait forever

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Run  in  1  start request, sampled only in IDLE
DIN  in  N  instruction word (IDLE), immediate (mvi T1), load data (MEM)
MemReady  in  1  memory accepts the store / presents load data this cycle
Done  out  1  one-cycle pulse on the instruction's final cycle
Err  out  1  one-cycle pulse together with Done when a memory access times out
BusWires  out  N  internal bus value (observable)
ADDR  out  N  registered memory address
DOUT  out  N  registered store data
W  out  1  store strobe, combinational: high in MEM while executing st

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; R0-R7, A, G, IR, ADDR, DOUT, timeout counter all 0; Done=Err=W=0; BusWires=0. Reset mid-instruction abandons it without writeback and without a Done pulse.
- Instruction: IR <= DIN[9:0]. Opcode I=IR[9:6]; X=IR[5:3], Y=IR[2:0] select Rx and Ry.
- FSM states: IDLE, T1, T2, T3, MEM.
- IDLE: if Run=1, load IR and go to T1; otherwise stay. BusWires=0.
- Opcodes and timing (Done in the listed cycle, then return to IDLE):
  0 ld: T1 bus=Ry, ADDR<=bus, go MEM. MEM: on MemReady, bus=DIN, Rx<=DIN, Done.
  1 st: T1 bus=Ry, ADDR<=bus, go T2. T2 bus=Rx, DOUT<=bus, go MEM. MEM: W=1; on MemReady, Done.
  2 mvnz: T1 if G!=0 then bus=Ry, Rx<=Ry; Done in T1 regardless of G.
  3 mv: T1 bus=Ry, Rx<=Ry, Done.
  4 mvi: T1 bus=DIN, Rx<=DIN, Done.
  5-10 ALU (add, sub, or, slt, sll, srl): T1 bus=Rx, A<=Rx. T2 bus=Ry, G<=f(A,Ry). T3 bus=G, Rx<=G, Done.
  11-15: no-op, Done in T1 (11 is mul when the optional feature is enabled).
- Arithmetic:
  - add/sub wrap modulo 2^N; no carry output.
  - or is bitwise.
  - slt: G=1 if A<Ry as two's-complement signed, else G=0.
  - sll/srl are logical; the shift amount is Ry taken as unsigned; if Ry>=N the result is 0.
- G is written only by ALU ops and persists across instructions for mvnz.
- Register conflicts: X==Y is legal; the read value is the pre-write value.
- MEM timeout:
  - Counter clears on MEM entry and increments each cycle MemReady=0.
  - If TIMEOUT!=0 and the count reaches TIMEOUT: Done=1, Err=1, no register write, return to IDLE.
  - MemReady in the same cycle the limit is reached wins: normal completion, Err=0.
- Latency: mv/mvi/mvnz/no-op = 2 cycles from the Run sample to Done; ALU = 4; ld = 3 + wait; st = 4 + wait.
- Run held high re-launches the next instruction in the cycle after Done (back-to-back, from IDLE).

Optional Feature:
PROC_GEN_MULT_EN
- Defined: opcode 11 = mul, with ALU-op timing; G <= low N bits of the unsigned product A*Ry.
- Undefined: opcode 11 is a no-op, Done in T1, G unchanged.

Test Plan:
- Reset, then Run with mvi R0 (DIN=0x100) and DIN=0x1234 in T1 -> R0=0x1234, Done exactly 2 cycles after the Run sample.
- N=16: mvi R1=0xFFFF, mvi R2=0x0001, add R1,R2 -> R1=0x0000. Then mvnz R3,R2 leaves R3 unchanged (G=0), with Done still pulsed.
- slt with R1=0x8000, R2=0x0001 -> G=1 and R1=1. sll with R1=0x0003, R2=16 -> R1=0.
- st R4->[R5] with R5=0x0040, R4=0xBEEF, MemReady delayed 3 cycles -> ADDR=0x0040, DOUT=0xBEEF, W high for 4 cycles, then Done.
- TIMEOUT=5, ld with MemReady held at 0 -> Done=Err=1 in the 5th MEM cycle, Rx unchanged. Repeat with MemReady on the 5th cycle -> Err=0 and data loaded.
- Assert Reset during T2 of an add -> all registers 0, state IDLE, no Done. Next Run executes normally.
